lsu_ctrl: RTL and testbench

//   Sequential load/store unit; successor to the combinational memory path of the backend datapath.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op bit positions, FSM encoding, lane masks and op decode.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned half/word ops into two accesses).
package lsu_pkg;

  localparam int unsigned WAIT_W = 4;

  localparam int unsigned OP_LB  = 7;
  localparam int unsigned OP_LH  = 6;
  localparam int unsigned OP_LW  = 5;
  localparam int unsigned OP_LBU = 4;
  localparam int unsigned OP_LHU = 3;
  localparam int unsigned OP_SB  = 2;
  localparam int unsigned OP_SH  = 1;
  localparam int unsigned OP_SW  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE = 4'h0;
  localparam logic [3:0] BE_LO   = 4'h3;
  localparam logic [3:0] BE_HI   = 4'hC;
  localparam logic [3:0] BE_ALL  = 4'hF;

  function automatic logic op_is_load(input logic [7:0] op);
    return op[OP_LB] | op[OP_LH] | op[OP_LW] | op[OP_LBU] | op[OP_LHU];
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    return op[OP_SB] | op[OP_SH] | op[OP_SW];
  endfunction

  function automatic logic op_is_byte(input logic [7:0] op);
    return op[OP_LB] | op[OP_LBU] | op[OP_SB];
  endfunction

  function automatic logic op_is_half(input logic [7:0] op);
    return op[OP_LH] | op[OP_LHU] | op[OP_SH];
  endfunction

  function automatic logic op_is_word(input logic [7:0] op);
    return op[OP_LW] | op[OP_SW];
  endfunction

  function automatic logic op_is_onehot(input logic [7:0] op);
    return (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  endfunction

  function automatic logic op_misaligned(input logic [7:0] op, input logic [1:0] off);
    return (op_is_half(op) && off[0]) || (op_is_word(op) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication and byte enables, load lane select and extension.
// With LSU_MISALIGN_SPLIT_EN, misaligned ops are steered across a two-word window.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  off,
`ifdef LSU_MISALIGN_SPLIT_EN
  input  logic        acc1,
  input  logic [31:0] lo_word,
`endif
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] mem_wdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane_c;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]  wide_be;
  logic [63:0] wide_wd;
`endif

  always_comb begin
    be        = BE_NONE;
    mem_wdata = wdata;
    lane_c    = rdata >> {off, 3'b000};
    if (op_is_byte(op)) begin
      be        = 4'(4'b0001 << off);
      mem_wdata = {4{wdata[7:0]}};
    end else if (op_is_half(op)) begin
      be        = off[1] ? BE_HI : BE_LO;
      mem_wdata = {2{wdata[15:0]}};
    end else if (op_is_word(op)) begin
      be        = BE_ALL;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    // Misaligned ops view {second word, first word} as one 64-bit window.
    wide_be = (op_is_half(op) ? 8'h03 : 8'h0F) << off;
    wide_wd = {32'd0, wdata} << {off, 3'b000};
    if (op_misaligned(op, off)) begin
      be        = acc1 ? wide_be[7:4] : wide_be[3:0];
      mem_wdata = acc1 ? wide_wd[63:32] : wide_wd[31:0];
      lane_c    = 32'({rdata, lo_word} >> {off, 3'b000});
    end
`endif
    ld_data = 32'd0;
    if (op[OP_LB])       ld_data = {{24{lane_c[7]}}, lane_c[7:0]};
    else if (op[OP_LBU]) ld_data = {24'd0, lane_c[7:0]};
    else if (op[OP_LH])  ld_data = {{16{lane_c[15]}}, lane_c[15:0]};
    else if (op[OP_LHU]) ld_data = {16'd0, lane_c[15:0]};
    else if (op[OP_LW])  ld_data = lane_c;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequential load/store unit driving a synchronous SRAM port with WAIT_STATES extra cycles per access.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned half/word ops become two back-to-back word accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          dbg_oe,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       lo_q, lo_d;
`endif

  logic              acc_c, acc1_c, last_c;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_ld;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign acc_c  = (state_q == ST_ACC0) || (state_q == ST_ACC1);
  assign acc1_c = (state_q == ST_ACC1);
  assign last_c = (cnt_q == WAIT_LAST);

  lsu_align u_align (
    .op        (op_q),
    .off       (addr_q[1:0]),
`ifdef LSU_MISALIGN_SPLIT_EN
    .acc1      (acc1_c),
    .lo_word   (lo_q),
`endif
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (al_be),
    .mem_wdata (al_wdata),
    .ld_data   (al_ld)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          cnt_d   = '0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (!op_is_onehot(req_op)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
`ifndef LSU_MISALIGN_SPLIT_EN
          else if (op_misaligned(req_op, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
`endif
          else begin
            state_d = ST_ACC0;
          end
        end
      end
      ST_ACC0: begin
        if (last_c) begin
          cnt_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (op_misaligned(op_q, addr_q[1:0])) begin
            lo_d    = mem_rdata;
            state_d = ST_ACC1;
          end else
`endif
          begin
            rdata_d = al_ld;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      ST_ACC1: begin
        if (last_c) begin
          cnt_d   = '0;
          rdata_d = al_ld;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q    <= lo_d;
`endif
    end
  end

  // Reset hands the SRAM port to the debug interface and silences the request side.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_oe     = dbg_oe;
    mem_we     = dbg_we;
    mem_be     = BE_ALL;
    mem_addr   = dbg_addr;
    mem_wdata  = dbg_wdata;
    if (!rst) begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
      resp_err   = (state_q == ST_RESP) && err_q;
      resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;
      mem_oe     = acc_c && op_is_load(op_q);
      mem_we     = acc_c && op_is_store(op_q);
      mem_be     = acc_c ? al_be : BE_NONE;
      mem_addr   = addr_q[AW+1:2] + AW'(acc1_c);
      mem_wdata  = al_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table on a zero-wait unit with an SRAM model, plus wait-state
// and reset-abort sequences on a three-wait unit. Honours LSU_MISALIGN_SPLIT_EN for misaligned cases.
module tb_lsu_ctrl;

  localparam int unsigned AW = 16;
  localparam int NV = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst3;
  logic          req_valid, req_ready, resp_valid, resp_err;
  logic [7:0]    req_op;
  logic [31:0]   req_addr, req_wdata, resp_rdata;
  logic          mem_oe, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic          req_valid3, req_ready3, resp_valid3, resp_err3;
  logic [7:0]    req_op3;
  logic [31:0]   req_addr3, req_wdata3, resp_rdata3;
  logic          mem_oe3, mem_we3;
  logic [3:0]    mem_be3;
  logic [AW-1:0] mem_addr3;
  logic [31:0]   mem_wdata3;

  logic          dbg_oe, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;

  logic [31:0] sram [0:(1<<AW)-1];

  lsu_ctrl #(.AW(AW), .WAIT_STATES(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_oe(mem_oe), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_oe(dbg_oe), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata)
  );

  lsu_ctrl #(.AW(AW), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
    .resp_err(resp_err3), .mem_oe(mem_oe3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(32'h12345678), .dbg_oe(dbg_oe), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata)
  );

  // Byte-lane SRAM model behind the zero-wait unit.
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          oe;
    int          we;
  } vec_t;

  vec_t vecs [NV];

  task automatic run_req(input vec_t v, output int lat, output logic [31:0] rd, output logic er,
                         output logic [3:0] be_or, output logic [31:0] wd, output int oe_n,
                         output int we_n, output int extra);
    lat = -1; rd = 32'd0; er = 1'b0; be_or = 4'd0; wd = 32'd0; oe_n = 0; we_n = 0; extra = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_oe) oe_n++;
      if (mem_we) begin we_n++; wd = mem_wdata; end
      be_or = be_or | mem_be;
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; break; end
    end
    @(negedge clk);
    if (resp_valid) extra = 1;
  endtask

  initial begin
    int lat, oe_n, we_n, extra, ready_low, pulses, resp_at, bad;
    logic [31:0] rd, wd;
    logic er;
    logic [3:0] be_or;

    //             op      addr      wdata         be     wd            chk   rdata         err lat oe we
    vecs[0]  = '{8'h01, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 2, 0, 1};
    vecs[1]  = '{8'h20, 32'h10, 32'h0,        4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 0};
    vecs[2]  = '{8'h20, 32'h14, 32'h0,        4'hF, 32'h0,        1'b0, 32'h55667788, 1'b0, 2, 1, 0};
    vecs[3]  = '{8'h01, 32'h20, 32'h80FF7F01, 4'hF, 32'h80FF7F01, 1'b1, 32'h0,        1'b0, 2, 0, 1};
    vecs[4]  = '{8'h80, 32'h23, 32'h0,        4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 2, 1, 0};
    vecs[5]  = '{8'h10, 32'h23, 32'h0,        4'h8, 32'h0,        1'b0, 32'h00000080, 1'b0, 2, 1, 0};
    vecs[6]  = '{8'h40, 32'h22, 32'h0,        4'hC, 32'h0,        1'b0, 32'hFFFF80FF, 1'b0, 2, 1, 0};
    vecs[7]  = '{8'h08, 32'h20, 32'h0,        4'h3, 32'h0,        1'b0, 32'h00007F01, 1'b0, 2, 1, 0};
    vecs[8]  = '{8'h80, 32'h20, 32'h0,        4'h1, 32'h0,        1'b0, 32'h00000001, 1'b0, 2, 1, 0};
    vecs[9]  = '{8'h01, 32'h20, 32'h11223344, 4'hF, 32'h11223344, 1'b1, 32'h0,        1'b0, 2, 0, 1};
    vecs[10] = '{8'h04, 32'h21, 32'hFFFFFFAB, 4'h2, 32'hABABABAB, 1'b1, 32'h0,        1'b0, 2, 0, 1};
    vecs[11] = '{8'h20, 32'h20, 32'h0,        4'hF, 32'h0,        1'b0, 32'h1122AB44, 1'b0, 2, 1, 0};
    vecs[12] = '{8'h02, 32'h22, 32'h1234BEEF, 4'hC, 32'hBEEFBEEF, 1'b1, 32'h0,        1'b0, 2, 0, 1};
    vecs[13] = '{8'h20, 32'h20, 32'h0,        4'hF, 32'h0,        1'b0, 32'hBEEFAB44, 1'b0, 2, 1, 0};
    vecs[14] = '{8'h03, 32'h20, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0, 0};
    vecs[15] = '{8'h00, 32'h20, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0, 0};
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs[16] = '{8'h40, 32'h21, 32'h0,        4'h6, 32'h0,        1'b0, 32'hFFFFEFAB, 1'b0, 3, 2, 0};
    vecs[17] = '{8'h20, 32'h13, 32'h0,        4'hF, 32'h0,        1'b0, 32'h667788DE, 1'b0, 3, 2, 0};
`else
    vecs[16] = '{8'h40, 32'h21, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0, 0};
    vecs[17] = '{8'h20, 32'h13, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0, 0};
`endif
    vecs[18] = '{8'h08, 32'h22, 32'h0,        4'hC, 32'h0,        1'b0, 32'h0000BEEF, 1'b0, 2, 1, 0};

    rst = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; req_op = 8'd0; req_addr = 32'd0; req_wdata = 32'd0;
    req_valid3 = 1'b0; req_op3 = 8'd0; req_addr3 = 32'd0; req_wdata3 = 32'd0;
    dbg_oe = 1'b0; dbg_we = 1'b1; dbg_addr = 16'd5; dbg_wdata = 32'h55667788;

    // Reset: outputs quiet, SRAM port follows debug (this also preloads word 5).
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'hF);
    chk("rst_mem_we", 32'(mem_we), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd5);
    chk("rst_mem_wdata", mem_wdata, 32'h55667788);
    dbg_we = 1'b0; dbg_oe = 1'b1; dbg_addr = 16'h0123;
    #1;
    chk("rst_mem_oe", 32'(mem_oe), 32'd1);
    chk("rst_mem_addr2", 32'(mem_addr), 32'h0123);
    @(negedge clk);
    dbg_oe = 1'b0; rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_mem_be", 32'(mem_be), 32'd0);
    chk("idle_mem_oe", 32'(mem_oe), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], lat, rd, er, be_or, wd, oe_n, we_n, extra);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
      chk($sformatf("v%0d_be", i), 32'(be_or), 32'(vecs[i].be));
      chk($sformatf("v%0d_oe_cycles", i), 32'(oe_n), 32'(vecs[i].oe));
      chk($sformatf("v%0d_we_cycles", i), 32'(we_n), 32'(vecs[i].we));
      chk($sformatf("v%0d_single_pulse", i), 32'(extra), 32'd0);
      if (vecs[i].chk_wd) chk($sformatf("v%0d_wdata", i), wd, vecs[i].wd);
    end

    // Three wait states with req_valid held across the whole transaction.
    @(negedge clk);
    req_valid3 = 1'b1; req_op3 = 8'h20; req_addr3 = 32'h40; req_wdata3 = 32'd0;
    chk("ws3_ready_before", 32'(req_ready3), 32'd1);
    ready_low = 0; oe_n = 0; pulses = 0; resp_at = -1; bad = 0; rd = 32'd0; er = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!req_ready3) ready_low++;
      if (mem_oe3) oe_n++;
      if (mem_oe3 && (mem_be3 != 4'hF || mem_addr3 != 16'h0010)) bad++;
      if (mem_we3) bad++;
      if (resp_valid3) begin pulses++; resp_at = k; rd = resp_rdata3; er = resp_err3; end
    end
    @(negedge clk);
    chk("ws3_ready_after", 32'(req_ready3), 32'd1);
    if (resp_valid3) pulses++;
    req_valid3 = 1'b0;
    chk("ws3_ready_low", 32'(ready_low), 32'd5);
    chk("ws3_oe_cycles", 32'(oe_n), 32'd4);
    chk("ws3_pulses", 32'(pulses), 32'd1);
    chk("ws3_latency", 32'(resp_at), 32'd5);
    chk("ws3_rdata", rd, 32'h12345678);
    chk("ws3_err", 32'(er), 32'd0);
    chk("ws3_port_bad", 32'(bad), 32'd0);

    // Reset in the middle of ACC0 abandons the access.
    @(negedge clk);
    req_valid3 = 1'b1; req_op3 = 8'h20; req_addr3 = 32'h44;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(negedge clk);
    chk("abort_acc_oe", 32'(mem_oe3), 32'd1);
    rst3 = 1'b1; dbg_oe = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0077; dbg_wdata = 32'hCAFEF00D;
    #1;
    chk("abort_mem_oe", 32'(mem_oe3), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr3), 32'h0077);
    chk("abort_mem_be", 32'(mem_be3), 32'hF);
    chk("abort_mem_wdata", mem_wdata3, 32'hCAFEF00D);
    chk("abort_ready", 32'(req_ready3), 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid3) pulses++;
    end
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid3) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    chk("abort_ready_after", 32'(req_ready3), 32'd1);
    chk("abort_oe_after", 32'(mem_oe3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
